register_file_param: RTL and testbench

//  Parametrised dual-read / single-write register file for the CPU datapath.

---
 rtl/register_file_param_if.sv | 30 +++
 rtl/register_file_param.sv | 91 +++++++++
 tb/tb_register_file_param.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_param_if.sv
// Bus bundle for register_file_param: read ports, write port, reserve port and scoreboard status.
interface register_file_param_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  i_read;
   logic [ADDR_WIDTH-1:0] i_addr_r1;
   logic [ADDR_WIDTH-1:0] i_addr_r2;
   logic [DATA_WIDTH-1:0] o_data_r1;
   logic [DATA_WIDTH-1:0] o_data_r2;
   logic                  o_busy_r1;
   logic                  o_busy_r2;
   logic                  o_rd_valid;
   logic                  i_write;
   logic [ADDR_WIDTH-1:0] i_addr_w;
   logic [DATA_WIDTH-1:0] i_data_w;
   logic                  i_reserve;
   logic [ADDR_WIDTH-1:0] i_addr_rsv;
   logic                  o_any_busy;

   modport master (
      output i_read, i_addr_r1, i_addr_r2, i_write, i_addr_w, i_data_w, i_reserve, i_addr_rsv,
      input  o_data_r1, o_data_r2, o_busy_r1, o_busy_r2, o_rd_valid, o_any_busy
   );

   modport slave (
      input  i_read, i_addr_r1, i_addr_r2, i_write, i_addr_w, i_data_w, i_reserve, i_addr_rsv,
      output o_data_r1, o_data_r2, o_busy_r1, o_busy_r2, o_rd_valid, o_any_busy
   );
endinterface

// File: rtl/register_file_param.sv
// Dual-read / single-write register file with registered reads, optional write->read bypass,
// optional hard-wired zero register and a per-register busy scoreboard for RAW hazard detection.
module register_file_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input logic                   i_clk,
   input logic                   i_rst,
   register_file_param_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic        ZR    = (ZERO_REG != 0);
   localparam logic        BP    = (BYPASS != 0);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]      r_busy;
   logic [DATA_WIDTH-1:0] r_data_r1;
   logic [DATA_WIDTH-1:0] r_data_r2;
   logic                  r_busy_r1;
   logic                  r_busy_r2;
   logic                  r_rd_valid;

   logic                  w_wr_en;
   logic                  w_rsv_en;
   logic [DEPTH-1:0]      w_busy_next;
   logic [DATA_WIDTH-1:0] w_rd_data1;
   logic [DATA_WIDTH-1:0] w_rd_data2;
   logic                  w_rd_busy1;
   logic                  w_rd_busy2;

   always_comb begin
      w_wr_en  = bus.i_write   && !(ZR && (bus.i_addr_w   == '0));
      w_rsv_en = bus.i_reserve && !(ZR && (bus.i_addr_rsv == '0));

      // Clear before set so a same-cycle reserve to the written register wins.
      w_busy_next = r_busy;
      if (w_wr_en)  w_busy_next[bus.i_addr_w]   = 1'b0;
      if (w_rsv_en) w_busy_next[bus.i_addr_rsv] = 1'b1;

      w_rd_data1 = r_mem[bus.i_addr_r1];
      w_rd_busy1 = r_busy[bus.i_addr_r1];
      if (ZR && (bus.i_addr_r1 == '0)) begin
         w_rd_data1 = '0;
         w_rd_busy1 = 1'b0;
      end else if (BP && bus.i_write && (bus.i_addr_w == bus.i_addr_r1)) begin
         w_rd_data1 = bus.i_data_w;
         w_rd_busy1 = 1'b0;
      end

      w_rd_data2 = r_mem[bus.i_addr_r2];
      w_rd_busy2 = r_busy[bus.i_addr_r2];
      if (ZR && (bus.i_addr_r2 == '0)) begin
         w_rd_data2 = '0;
         w_rd_busy2 = 1'b0;
      end else if (BP && bus.i_write && (bus.i_addr_w == bus.i_addr_r2)) begin
         w_rd_data2 = bus.i_data_w;
         w_rd_busy2 = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_busy     <= '0;
         r_data_r1  <= '0;
         r_data_r2  <= '0;
         r_busy_r1  <= 1'b0;
         r_busy_r2  <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_wr_en) r_mem[bus.i_addr_w] <= bus.i_data_w;
         r_busy     <= w_busy_next;
         r_rd_valid <= bus.i_read;
         if (bus.i_read) begin
            r_data_r1 <= w_rd_data1;
            r_data_r2 <= w_rd_data2;
            r_busy_r1 <= w_rd_busy1;
            r_busy_r2 <= w_rd_busy2;
         end
      end
   end

   assign bus.o_data_r1  = r_data_r1;
   assign bus.o_data_r2  = r_data_r2;
   assign bus.o_busy_r1  = r_busy_r1;
   assign bus.o_busy_r2  = r_busy_r2;
   assign bus.o_rd_valid = r_rd_valid;
   assign bus.o_any_busy = |r_busy;
endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: two instances (ZERO_REG=1/BYPASS=1 and ZERO_REG=0/BYPASS=0)
// driven by the same stimulus, checked each cycle against a behavioural model plus literal pins.
module tb_register_file_param;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int N  = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_read, s_write, s_reserve;
   logic [AW-1:0] s_a1, s_a2, s_aw, s_ar;
   logic [DW-1:0] s_dw;

   always #5 clk = ~clk;

   register_file_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
   register_file_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

   assign bus_a.i_read = s_read;     assign bus_b.i_read = s_read;
   assign bus_a.i_addr_r1 = s_a1;    assign bus_b.i_addr_r1 = s_a1;
   assign bus_a.i_addr_r2 = s_a2;    assign bus_b.i_addr_r2 = s_a2;
   assign bus_a.i_write = s_write;   assign bus_b.i_write = s_write;
   assign bus_a.i_addr_w = s_aw;     assign bus_b.i_addr_w = s_aw;
   assign bus_a.i_data_w = s_dw;     assign bus_b.i_data_w = s_dw;
   assign bus_a.i_reserve = s_reserve; assign bus_b.i_reserve = s_reserve;
   assign bus_a.i_addr_rsv = s_ar;   assign bus_b.i_addr_rsv = s_ar;

   register_file_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1), .BYPASS(1))
      dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
   register_file_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0), .BYPASS(0))
      dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model state, index 0 = instance A, 1 = instance B
   bit            m_zr [2] = '{1'b1, 1'b0};
   bit            m_bp [2] = '{1'b1, 1'b0};
   logic [DW-1:0] m_mem  [2][N];
   bit            m_busy [2][N];
   logic [DW-1:0] e_d1 [2], e_d2 [2];
   bit            e_b1 [2], e_b2 [2], e_v [2];

   function automatic logic [DW-1:0] m_rd_data(input int k, input logic [AW-1:0] a);
      if (m_zr[k] && a == 0) return '0;
      if (m_bp[k] && s_write && s_aw == a) return s_dw;
      return m_mem[k][a];
   endfunction

   function automatic bit m_rd_busy(input int k, input logic [AW-1:0] a);
      if (m_zr[k] && a == 0) return 1'b0;
      if (m_bp[k] && s_write && s_aw == a) return 1'b0;
      return m_busy[k][a];
   endfunction

   function automatic bit m_any(input int k);
      for (int i = 0; i < N; i++) if (m_busy[k][i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int i = 0; i < N; i++) begin
               m_mem[k][i] = '0;
               m_busy[k][i] = 1'b0;
            end
            e_d1[k] = '0; e_d2[k] = '0; e_b1[k] = 0; e_b2[k] = 0; e_v[k] = 0;
         end else begin
            e_v[k] = s_read;
            if (s_read) begin
               e_d1[k] = m_rd_data(k, s_a1);
               e_d2[k] = m_rd_data(k, s_a2);
               e_b1[k] = m_rd_busy(k, s_a1);
               e_b2[k] = m_rd_busy(k, s_a2);
            end
            if (s_write && !(m_zr[k] && s_aw == 0)) begin
               m_mem[k][s_aw]  = s_dw;
               m_busy[k][s_aw] = 1'b0;
            end
            if (s_reserve && !(m_zr[k] && s_ar == 0)) m_busy[k][s_ar] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("A.data_r1", bus_a.o_data_r1, e_d1[0]);
         chk("A.data_r2", bus_a.o_data_r2, e_d2[0]);
         chk("A.busy_r1", 32'(bus_a.o_busy_r1), 32'(e_b1[0]));
         chk("A.busy_r2", 32'(bus_a.o_busy_r2), 32'(e_b2[0]));
         chk("A.rd_valid", 32'(bus_a.o_rd_valid), 32'(e_v[0]));
         chk("A.any_busy", 32'(bus_a.o_any_busy), 32'(m_any(0)));
         chk("B.data_r1", bus_b.o_data_r1, e_d1[1]);
         chk("B.data_r2", bus_b.o_data_r2, e_d2[1]);
         chk("B.busy_r1", 32'(bus_b.o_busy_r1), 32'(e_b1[1]));
         chk("B.busy_r2", 32'(bus_b.o_busy_r2), 32'(e_b2[1]));
         chk("B.rd_valid", 32'(bus_b.o_rd_valid), 32'(e_v[1]));
         chk("B.any_busy", 32'(bus_b.o_any_busy), 32'(m_any(1)));
      end
   end

   task automatic idle();
      rst = 0; s_read = 0; s_write = 0; s_reserve = 0;
      s_a1 = '0; s_a2 = '0; s_aw = '0; s_ar = '0; s_dw = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      s_write = 1; s_aw = a; s_dw = d;
      step();
   endtask

   task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      s_read = 1; s_a1 = a1; s_a2 = a2;
      step();
   endtask

   initial begin
      idle();
      rst = 1;
      step();
      checking = 1'b1;

      // T1: preload, reserve, then reset with a read in flight
      for (int a = 1; a < N; a++) do_write(AW'(a), 32'hA500_0000 | a);
      s_reserve = 1; s_ar = 5'd4; step();
      rst = 1; s_read = 1; s_a1 = 5'd1; s_a2 = 5'd31; step();
      chk("T1.rst_data_r1", bus_a.o_data_r1, 32'h0);
      chk("T1.rst_valid", 32'(bus_a.o_rd_valid), 32'h0);
      chk("T1.rst_any_busy", 32'(bus_a.o_any_busy), 32'h0);
      for (int a = 0; a < N; a++) begin
         do_read(AW'(a), AW'(N - 1 - a));
         chk("T1.zero_r1", bus_b.o_data_r1, 32'h0);
      end

      // T2: write then dual read of same register
      do_write(5'd5, 32'hDEADBEEF);
      do_read(5'd5, 5'd5);
      chk("T2.a_r1", bus_a.o_data_r1, 32'hDEADBEEF);
      chk("T2.a_r2", bus_a.o_data_r2, 32'hDEADBEEF);
      chk("T2.valid", 32'(bus_a.o_rd_valid), 32'h1);
      chk("T2.model_r1", e_d1[0], 32'hDEADBEEF);

      // T3: bypass vs no bypass
      do_write(5'd7, 32'h1);
      s_write = 1; s_aw = 5'd7; s_dw = 32'h12345678; s_read = 1; s_a1 = 5'd7; step();
      chk("T3.bypass_data", bus_a.o_data_r1, 32'h12345678);
      chk("T3.bypass_busy", 32'(bus_a.o_busy_r1), 32'h0);
      chk("T3.nobypass_data", bus_b.o_data_r1, 32'h1);
      chk("T3.model_nobypass", e_d1[1], 32'h1);

      // T4: register 0 hard-wired (A) vs ordinary (B)
      s_write = 1; s_aw = 5'd0; s_dw = 32'hFFFFFFFF; s_reserve = 1; s_ar = 5'd0; step();
      do_read(5'd0, 5'd0);
      chk("T4.zero_data", bus_a.o_data_r1, 32'h0);
      chk("T4.zero_busy", 32'(bus_a.o_busy_r1), 32'h0);
      chk("T4.zero_any", 32'(bus_a.o_any_busy), 32'h0);
      chk("T4.plain_data", bus_b.o_data_r1, 32'hFFFFFFFF);
      chk("T4.plain_busy", 32'(bus_b.o_busy_r1), 32'h1);
      do_write(5'd0, 32'h0);

      // T5: scoreboard
      s_reserve = 1; s_ar = 5'd3; step();
      do_read(5'd1, 5'd3);
      chk("T5.rsv_busy", 32'(bus_a.o_busy_r2), 32'h1);
      chk("T5.rsv_any", 32'(bus_a.o_any_busy), 32'h1);
      s_reserve = 1; s_ar = 5'd3; s_write = 1; s_aw = 5'd3; s_dw = 32'h33; step();
      do_read(5'd1, 5'd3);
      chk("T5.rsv_wins_busy", 32'(bus_a.o_busy_r2), 32'h1);
      chk("T5.rsv_wins_data", bus_a.o_data_r2, 32'h33);
      do_write(5'd3, 32'h44);
      do_read(5'd1, 5'd3);
      chk("T5.clr_busy", 32'(bus_a.o_busy_r2), 32'h0);
      chk("T5.clr_any", 32'(bus_a.o_any_busy), 32'h0);
      s_reserve = 1; s_ar = 5'd6; step();
      s_write = 1; s_aw = 5'd6; s_dw = 32'h66; s_read = 1; s_a1 = 5'd6; s_a2 = 5'd6; step();
      chk("T5.byp_busy_a", 32'(bus_a.o_busy_r1), 32'h0);
      chk("T5.nobyp_busy_b", 32'(bus_b.o_busy_r1), 32'h1);

      // T6: hold, then reset overriding a write
      do_read(5'd3, 5'd5);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("T6.hold_r1", bus_a.o_data_r1, 32'h44);
         chk("T6.hold_r2", bus_a.o_data_r2, 32'hDEADBEEF);
         chk("T6.hold_valid", 32'(bus_a.o_rd_valid), 32'h0);
      end
      rst = 1; s_write = 1; s_aw = 5'd9; s_dw = 32'h99; step();
      do_read(5'd9, 5'd9);
      chk("T6.rst_write_a", bus_a.o_data_r1, 32'h0);
      chk("T6.rst_write_b", bus_b.o_data_r2, 32'h0);

      // Mixed traffic over a small address window
      for (int i = 0; i < 300; i++) begin
         rst       = ($urandom_range(0, 40) == 0);
         s_read    = 1'($urandom);
         s_write   = 1'($urandom);
         s_reserve = ($urandom_range(0, 2) == 0);
         s_a1      = AW'($urandom_range(0, 7));
         s_a2      = AW'($urandom_range(0, 7));
         s_aw      = AW'($urandom_range(0, 7));
         s_ar      = AW'($urandom_range(0, 7));
         s_dw      = $urandom;
         @(posedge clk);
         #1;
      end
      idle();
      step();
      checking = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
